rr_priority_arbiter: RTL and testbench

- Round-robin arbiter that shares one resource (e.g. the downstream consumer of the 8:3 encoder datapath) among 8 requesters.
- Rotating-priority search from a pointer; the grant is held while the winner keeps its request, with a hold-time limit.
- Outputs a one-hot grant plus an encoded 3-bit grant index in the same format the 8:3 priority encoder produces.
- Sits between the requesting blocks and the shared resource's enable/select inputs.

---
 rtl/rr_priority_arbiter.sv | 106 ++++++++++
 tb/tb_rr_priority_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_priority_arbiter.sv
// Round-robin arbiter for 8 requesters sharing one resource.
// A grant is held while the winner keeps requesting, for at most MAX_HOLD
// cycles. Every grant is followed by at least one idle cycle. The search
// pointer moves past the released owner, so that owner has the lowest
// priority at the next evaluation.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no grant; the next edge with en=1 and req!=0 picks a winner
// GRANT | gnt/gnt_id hold the winner; release conditions checked each edge
module rr_priority_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 gnt_valid,
  output logic                 timeout
);

  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [HW-1:0] hold_cnt;

  logic [IW-1:0] win_id;
  logic          win_found;
  logic [IW-1:0] cand;

  // Rotating search from ptr. Scanning from the farthest offset down means
  // the closest set bit to ptr is the last one written and therefore wins.
  // The index wraps naturally because N is a power of two.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = ptr + IW'(k);
      if (req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // Arbitration FSM with registered grant outputs and a one-cycle timeout pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (en && win_found) begin
            state     <= GRANT;
            gnt       <= N'(1) << win_id;
            gnt_id    <= win_id;
            gnt_valid <= 1'b1;
            hold_cnt  <= HW'(1);
          end
        end
        GRANT: begin
          if (!en || !req[gnt_id]) begin
            // A voluntary release or an abort never reports a timeout,
            // even when it coincides with the hold limit.
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            ptr       <= gnt_id + IW'(1);
          end else if (hold_cnt == HW'(MAX_HOLD)) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            ptr       <= gnt_id + IW'(1);
            timeout   <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= '0;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed bench for rr_priority_arbiter with a transaction-level reference
// model checked every cycle, plus hand-computed literal checkpoints.
module tb_rr_priority_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model: who owns the resource, for how long, and where the
  // next search starts.
  bit m_busy;
  int m_owner;
  int m_cnt;
  int m_ptr;
  bit m_to;

  rr_priority_arbiter #(.N(8), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk3(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on the same edges as the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_owner = 0;
      m_cnt   = 0;
      m_ptr   = 0;
      m_to    = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_busy) begin
        if (!en || !req[m_owner]) begin
          m_busy = 1'b0;
          m_ptr  = (m_owner + 1) % 8;
        end else if (m_cnt == MAX_HOLD) begin
          m_busy = 1'b0;
          m_ptr  = (m_owner + 1) % 8;
          m_to   = 1'b1;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end else if (en && req != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          if (req[(m_ptr + k) % 8]) begin
            m_owner = (m_ptr + k) % 8;
            break;
          end
        end
        m_busy = 1'b1;
        m_cnt  = 1;
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk8("model_gnt", gnt, m_busy ? (8'd1 << m_owner) : 8'd0);
      chk1("model_gnt_valid", gnt_valid, m_busy);
      chk1("model_timeout", timeout, m_to);
      if (m_busy) chk3("model_gnt_id", gnt_id, 3'(m_owner));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 8'hFF;
    #1 chk_en = 1'b1;

    // 1. Reset with all requests pending, then first grant to 0.
    repeat (3) cyc();
    chk8("rst_gnt", gnt, 8'h00);
    chk1("rst_valid", gnt_valid, 1'b0);
    chk3("rst_id", gnt_id, 3'd0);
    chk1("rst_timeout", timeout, 1'b0);
    rst_n = 1'b1;
    cyc();
    chk8("first_gnt", gnt, 8'h01);
    chk3("first_id", gnt_id, 3'd0);
    req = 8'h00;
    cyc();
    chk8("first_rel", gnt, 8'h00);

    // 2. Single requester 2, held 3 cycles, ptr then 3.
    req = 8'b0000_0100;
    cyc();
    chk8("single_gnt", gnt, 8'h04);
    chk3("single_id", gnt_id, 3'd2);
    cyc();
    cyc();
    req = 8'h00;
    cyc();
    chk8("single_rel", gnt, 8'h00);
    chk1("single_rel_to", timeout, 1'b0);
    req = 8'b0000_1001;
    cyc();
    chk3("ptr3_id", gnt_id, 3'd3);
    req = 8'h00;
    cyc();

    // Park ptr at 0 via a grant to 7.
    req = 8'h80;
    cyc();
    chk3("park_id", gnt_id, 3'd7);
    req = 8'h00;
    cyc();

    // 3. Round robin with all requesting.
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      cyc();
      chk3("rr_id", gnt_id, 3'(i % 8));
      chk8("rr_gnt", gnt, 8'd1 << (i % 8));
      cyc();
      req[i % 8] = 1'b0;
      cyc();
      chk1("rr_gap", gnt_valid, 1'b0);
      req[i % 8] = 1'b1;
    end
    req = 8'h00;

    // 4. Wrap: grant 5 -> ptr 6, then {5,0} grants 0 then 5.
    req = 8'b0010_0000;
    cyc();
    chk3("wrap5_id", gnt_id, 3'd5);
    req = 8'h00;
    cyc();
    req = 8'b0010_0001;
    cyc();
    chk3("wrap0_id", gnt_id, 3'd0);
    req = 8'b0010_0000;
    cyc();
    chk8("wrap0_rel", gnt, 8'h00);
    cyc();
    chk3("wrap5b_id", gnt_id, 3'd5);
    req = 8'h00;
    cyc();

    // 5. Timeout on requester 3, then regrant.
    req = 8'b0000_1000;
    cyc();
    chk8("hold_gnt_1", gnt, 8'h08);
    for (int k = 2; k <= MAX_HOLD; k++) begin
      cyc();
      chk8("hold_gnt", gnt, 8'h08);
    end
    cyc();
    chk8("to_gnt", gnt, 8'h00);
    chk1("to_pulse", timeout, 1'b1);
    cyc();
    chk8("regrant_gnt", gnt, 8'h08);
    chk1("regrant_to", timeout, 1'b0);
    // Release coinciding with the hold limit is not a timeout.
    repeat (MAX_HOLD - 1) cyc();
    req = 8'h00;
    cyc();
    chk8("coinc_gnt", gnt, 8'h00);
    chk1("coinc_to", timeout, 1'b0);

    // 6. Abort via en on requester 6, ptr then 7.
    req = 8'b0100_0000;
    cyc();
    chk3("abort_id", gnt_id, 3'd6);
    cyc();
    en = 1'b0;
    cyc();
    chk8("abort_gnt", gnt, 8'h00);
    chk1("abort_to", timeout, 1'b0);
    en  = 1'b1;
    req = 8'b1100_0000;
    cyc();
    chk3("ptr7_id", gnt_id, 3'd7);
    req = 8'h00;
    cyc();
    // en=0 at the hold limit wins over timeout.
    req = 8'b0100_0000;
    cyc();
    chk3("enprec_id", gnt_id, 3'd6);
    repeat (MAX_HOLD - 1) cyc();
    en = 1'b0;
    cyc();
    chk8("enprec_gnt", gnt, 8'h00);
    chk1("enprec_to", timeout, 1'b0);
    // en=0 blocks new grants.
    req = 8'hFF;
    cyc();
    cyc();
    chk8("en_off_gnt", gnt, 8'h00);
    en = 1'b1;
    cyc();
    chk3("en_on_id", gnt_id, 3'd7);

    // Asynchronous reset mid-grant.
    #1 rst_n = 1'b0;
    #1;
    chk8("async_gnt", gnt, 8'h00);
    chk1("async_valid", gnt_valid, 1'b0);
    chk3("async_id", gnt_id, 3'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc();
    chk3("post_rst_id", gnt_id, 3'd0);
    chk8("post_rst_gnt", gnt, 8'h01);
    req = 8'h00;
    cyc();
    cyc();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
